// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_arb_pkg: owner encoding, starvation counter width and STARVE_LIMIT range shared by the arbiter files
// Contents: owner_e (OWN_NONE/OWN_CPU/OWN_DMA), STARVE_W, STARVE_LIMIT_MIN/MAX, clamp_limit()
package dmem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_e;
  localparam int STARVE_W = 4;
  localparam int STARVE_LIMIT_MIN = 1;
  localparam int STARVE_LIMIT_MAX = 15;
  // An out-of-range limit is pulled into 1..15 so the 4-bit counter can always reach it.
  function automatic logic [STARVE_W-1:0] clamp_limit(input int lim);
    return STARVE_W'(lim < STARVE_LIMIT_MIN ? STARVE_LIMIT_MIN : lim > STARVE_LIMIT_MAX ? STARVE_LIMIT_MAX : lim);
  endfunction
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: MW-stage, DMA and data_mem signals around the data memory arbiter
// slave  : arbiter side (takes cpu_*/dma_* requests and mem_rdata, drives grants, stall and mem_*)
// master : environment side (pipeline, DMA engine and data_mem)
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_port_arbiter_starve_counter.sv
// arb_starve_counter: counts consecutive denied DMA cycles and raises force_dma when the limit is reached
// Ports: clk, reset (async, active-high), dma_req, dma_gnt in; force_dma out (registered)
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);
  localparam logic [STARVE_W-1:0] LIM = clamp_limit(STARVE_LIMIT);
  logic [STARVE_W-1:0] cnt, cnt_nxt;
  logic force_nxt;
  // A grant or a withdrawn request drops the force; otherwise it latches once the count hits the limit.
  always_comb begin
    cnt_nxt = dma_gnt ? '0 : dma_req ? cnt + 1'b1 : cnt;
    force_nxt = dma_req & ~dma_gnt & (force_dma | (cnt_nxt >= LIM));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      force_dma <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      force_dma <= force_nxt;
    end
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares data_mem between the MW stage (priority) and a DMA/debug requester
// Ports: clk, reset (async, active-high); bus (dmem_port_arbiter_if.slave) carrying cpu_*, dma_*, mem_*
// Optional: DMEM_ARB_STATS_EN adds stat_dma_grants / stat_cpu_stalls (16-bit saturating) outputs
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_dma_grants,
  output logic [15:0] stat_cpu_stalls
`endif
);
  owner_e owner;
  logic cpu_act, force_dma, gnt, stall, rd, wr, rvalid_q;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux, rdata_q;
  always_comb begin
    cpu_act = bus.cpu_mem_read | bus.cpu_mem_write;
    owner = (bus.dma_req & (force_dma | ~cpu_act)) ? OWN_DMA : cpu_act ? OWN_CPU : OWN_NONE;
    gnt = owner == OWN_DMA;
    stall = gnt & cpu_act;
    addr_mux = gnt ? bus.dma_addr : owner == OWN_CPU ? bus.cpu_addr : '0;
    wdata_mux = gnt ? bus.dma_wdata : owner == OWN_CPU ? bus.cpu_wdata : '0;
    rd = gnt ? ~bus.dma_we : owner == OWN_CPU & bus.cpu_mem_read;
    wr = gnt ? bus.dma_we : owner == OWN_CPU & bus.cpu_mem_write;
  end
  assign bus.mem_addr = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_read = rd;
  assign bus.mem_write = wr;
  assign bus.dma_gnt = gnt;
  assign bus.cpu_stall = stall;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = rdata_q;
  assign bus.dma_rvalid = rvalid_q;
  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .reset(reset),
    .dma_req(bus.dma_req),
    .dma_gnt(gnt),
    .force_dma(force_dma)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= gnt & ~bus.dma_we;
      if (gnt & ~bus.dma_we) rdata_q <= bus.mem_rdata;
    end
  end
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dma_grants <= '0;
      stat_cpu_stalls <= '0;
    end else begin
      if (gnt & ~&stat_dma_grants) stat_dma_grants <= stat_dma_grants + 16'd1;
      if (stall & ~&stat_cpu_stalls) stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
    end
  end
`endif
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between the pipeline's memory/writeback (MW) stage and a secondary DMA/debug requester.
- CPU has priority by default. A starvation counter guarantees forward progress for DMA; while DMA holds the port, the arbiter stalls the CPU.
- Sits between the MW-stage control/data signals and data_mem. Its stall output is ORed into the pipeline's load-use stall.

Parameters:
- ADDR_W, 32, byte-address width on both requester ports and the memory port.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA is forced in; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_mem_read  in  1  MW-stage load request.
- cpu_mem_write  in  1  MW-stage store request.
- cpu_addr  in  ADDR_W  MW-stage address (ALU result).
- cpu_wdata  in  DATA_W  MW-stage store data.
- cpu_rdata  out  DATA_W  load data to the writeback mux; combinational from mem_rdata.
- cpu_stall  out  1  CPU access denied this cycle; the pipeline holds MW and all earlier stages.
- dma_req  in  1  DMA access request; held high with stable fields until granted.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rdata  out  DATA_W  registered read data.
- dma_rvalid  out  1  one-cycle pulse, one cycle after a granted DMA read.
- mem_addr  out  ADDR_W  to data_mem.
- mem_wdata  out  DATA_W  to data_mem.
- mem_read  out  1  to data_mem.
- mem_write  out  1  to data_mem; the write commits on the clk edge.
- mem_rdata  in  DATA_W  combinational read data from data_mem.

Behaviour:
- cpu_act = cpu_mem_read | cpu_mem_write.
- force_dma is a registered flag. Owner is combinational each cycle:
  - DMA if dma_req & (force_dma | ~cpu_act);
  - else CPU if cpu_act;
  - else none.
- Owner CPU:
  - mem_* driven from cpu_* fields; dma_gnt = 0; cpu_stall = 0.
- Owner DMA:
  - mem_addr = dma_addr, mem_wdata = dma_wdata, mem_write = dma_we, mem_read = ~dma_we.
  - dma_gnt = 1; cpu_stall = cpu_act.
- Owner none:
  - mem_read = mem_write = 0; mem_addr and mem_wdata = 0.
- Starvation counter (4 bits):
  - Increments on each cycle with dma_req & ~dma_gnt.
  - Clears on dma_gnt.
  - Holds when dma_req = 0.
- force_dma:
  - Sets on the clock edge where the counter would reach STARVE_LIMIT, so DMA wins on the next cycle.
  - Clears on the edge after a granted DMA cycle.
  - Consequence: a continuously requesting DMA gets exactly one forced slot per STARVE_LIMIT+1 cycles under continuous CPU traffic.
- DMA read latency is 1:
  - On a granted read edge, dma_rdata <= mem_rdata and dma_rvalid <= 1.
  - Otherwise dma_rvalid <= 0 and dma_rdata holds.
- Simultaneous events:
  - CPU and DMA both requesting with force_dma = 0: CPU wins and the counter increments.
  - dma_req dropping while force_dma = 1 (protocol violation): force_dma clears on the next edge and the CPU is not stalled.
- STARVE_LIMIT = 1: DMA alternates with the CPU every other cycle under full contention.
- Reset (asynchronous, any time, including mid-stall or with dma_rvalid pending):
  - Counter = 0, force_dma = 0, dma_rvalid = 0, dma_rdata = 0.
  - Combinational outputs follow the rules above with the cleared state.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds two outputs, stat_dma_grants (16) and stat_cpu_stalls (16).
  - Saturating counters, reset to 0.
  - stat_dma_grants increments per dma_gnt cycle; stat_cpu_stalls increments per cpu_stall cycle.
- Undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner encoding: OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2;
  - STARVE_W = 4;
  - the STARVE_LIMIT legal-range constants.
- One sub-module, arb_starve_counter: the counter plus force_dma flag, with inputs dma_req and dma_gnt and output force_dma.
- Owner and mux logic stay in the top module.

Test Plan:
- Idle, then DMA read of addr 0x10010000 (memory holds 0xDEADBEEF), no CPU traffic -> dma_gnt = 1 in the same cycle; next cycle dma_rvalid = 1 and dma_rdata = 0xDEADBEEF; cpu_stall never asserts.
- Continuous CPU loads plus a DMA write of 0x12345678 to 0x10010004, STARVE_LIMIT = 4 -> 4 cycles of dma_gnt = 0, then on the 5th cycle dma_gnt = 1 and cpu_stall = 1; memory word becomes 0x12345678; cpu_stall = 0 on the following cycle.
- CPU store and DMA request in the same cycle with counter = 0 -> CPU store commits and counter = 1.
- Reset pulsed asynchronously mid-cycle while force_dma = 1 and dma_rvalid = 1 -> all state 0 immediately, before the next edge.
- STARVE_LIMIT = 1 with continuous contention over 8 cycles -> grants alternate CPU, DMA, CPU, DMA… with 4 DMA grants.
- With DMEM_ARB_STATS_EN defined, run scenario 2 -> stat_dma_grants = 1 and stat_cpu_stalls = 1; force 70000 stall cycles -> stat_cpu_stalls saturates at 0xFFFF.
